// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall controller: load-use bubbles, branch squash, multdiv start/ready freeze; STALL_PERF_CNT_EN adds perf counters.
// Latency: all latch/PC controls are combinational from the current IRs and FSM state (zero cycles).
// Backpressure: the pipeline freezes from the multdiv start until md_ready or until the watchdog expires.
module pipeline_stall_ctrl #(
    parameter int CNT_W         = 32,
    parameter int MD_MAX_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    input  logic        branch_taken,
    input  logic        md_ready,
    output logic        pc_we,
    output logic        fd_we,
    output logic        dx_we,
    output logic        xm_we,
    output logic        mw_we,
    output logic        fd_nop,
    output logic        dx_nop,
    output logic        xm_nop,
    output logic        md_mult,
    output logic        md_div,
    output logic        md_timeout
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
`endif
);

    localparam int WD_W = $clog2(MD_MAX_CYCLES + 1);

    typedef enum logic {RUN, MD_WAIT} state_t;

    state_t            stateQ, stateD;
    logic [WD_W-1:0]   wdQ, wdD;
    logic              timeoutQ, timeoutD;
    logic              flushAcc;

    logic [4:0] fdOp, fdRd, fdRs, fdRt, dxOp, dxRd, dxAlu;
    logic       dxMul, dxDiv, dxLw, fdUsesRs, fdUsesRt, fdUsesRd, loadUse;
    logic       unusedBits;

    assign fdOp  = fd_ir[31:27];
    assign fdRd  = fd_ir[26:22];
    assign fdRs  = fd_ir[21:17];
    assign fdRt  = fd_ir[16:12];
    assign dxOp  = dx_ir[31:27];
    assign dxRd  = dx_ir[26:22];
    assign dxAlu = dx_ir[6:2];
    assign unusedBits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

    assign dxMul = (dxOp == 5'b00000) && (dxAlu == 5'b00110);
    assign dxDiv = (dxOp == 5'b00000) && (dxAlu == 5'b00111);
    assign dxLw  = (dxOp == 5'b01000);

    always_comb begin
        fdUsesRs = 1'b0;
        fdUsesRd = 1'b0;
        case (fdOp)
            5'b00000, 5'b00101, 5'b01000: fdUsesRs = 1'b1;
            5'b00111, 5'b00010, 5'b00110: begin
                fdUsesRs = 1'b1;
                fdUsesRd = 1'b1;
            end
            5'b00100:                     fdUsesRd = 1'b1;
            default: ;
        endcase
    end

    assign fdUsesRt = (fdOp == 5'b00000);

    // r0 is hardwired zero, so a load into it can never feed a consumer.
    assign loadUse = dxLw && (dxRd != 5'd0) &&
                     ((fdUsesRs && (fdRs == dxRd)) ||
                      (fdUsesRt && (fdRt == dxRd)) ||
                      (fdUsesRd && (fdRd == dxRd)));

    always_comb begin
        pc_we    = 1'b1;
        fd_we    = 1'b1;
        dx_we    = 1'b1;
        xm_we    = 1'b1;
        mw_we    = 1'b1;
        fd_nop   = 1'b0;
        dx_nop   = 1'b0;
        xm_nop   = 1'b0;
        md_mult  = 1'b0;
        md_div   = 1'b0;
        flushAcc = 1'b0;
        stateD   = stateQ;
        wdD      = wdQ;
        timeoutD = timeoutQ;
        if (!reset) begin
            case (stateQ)
                RUN: begin
                    if (dxMul || dxDiv) begin
                        md_mult = dxMul;
                        md_div  = dxDiv;
                        pc_we   = 1'b0;
                        fd_we   = 1'b0;
                        dx_we   = 1'b0;
                        xm_nop  = 1'b1;
                        stateD  = MD_WAIT;
                        wdD     = WD_W'(1);
                    end else if (branch_taken) begin
                        fd_nop   = 1'b1;
                        dx_nop   = 1'b1;
                        flushAcc = 1'b1;
                    end else if (loadUse) begin
                        pc_we  = 1'b0;
                        fd_we  = 1'b0;
                        dx_nop = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (md_ready) begin
                        // Result lands in X/M; the mul/div in D/X is replaced so it cannot re-issue.
                        dx_nop = 1'b1;
                        stateD = RUN;
                    end else begin
                        pc_we  = 1'b0;
                        fd_we  = 1'b0;
                        dx_we  = 1'b0;
                        xm_nop = 1'b1;
                        wdD    = wdQ + 1'b1;
                        if (wdQ >= WD_W'(MD_MAX_CYCLES - 1)) begin
                            timeoutD = 1'b1;
                            stateD   = RUN;
                        end
                    end
                end
                default: stateD = RUN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ   <= RUN;
            wdQ      <= '0;
            timeoutQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            wdQ      <= wdD;
            timeoutQ <= timeoutD;
        end
    end

    assign md_timeout = timeoutQ && !reset;

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_we)
                stall_cycles <= stall_cycles + 1'b1;
            if (flushAcc)
                flush_events <= flush_events + 1'b1;
        end
    end
`else
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Hazard and stall controller for the 5-stage processor pipeline. It reads the instruction words held in the F/D and D/X pipeline latches and drives the write-enables and bubble-insert controls of the PC and of every pipeline latch. It resolves three cases:
- load-use hazards
- branch/jump flushes
- multi-cycle mult/div operations, through a start/ready handshake with the multdiv unit

Parameters:
CNT_W, 32, width of the performance counters (optional feature only).
MD_MAX_CYCLES, 40, watchdog limit in cycles for one multdiv operation.

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-high.
fd_ir  input  32  instruction in F/D latch.
dx_ir  input  32  instruction in D/X latch.
branch_taken  input  1  X stage resolved a taken branch or jump this cycle.
md_ready  input  1  multdiv result valid (data_resultRDY).
pc_we  output  1  PC register write-enable.
fd_we  output  1  F/D latch write-enable.
dx_we  output  1  D/X latch write-enable.
xm_we  output  1  X/M latch write-enable.
mw_we  output  1  M/W latch write-enable; always 1.
fd_nop  output  1  select nop (32'b0) as F/D input IR.
dx_nop  output  1  select nop as D/X input IR.
xm_nop  output  1  select nop as X/M input IR.
md_mult  output  1  one-cycle ctrl_mult pulse.
md_div  output  1  one-cycle ctrl_div pulse.
md_timeout  output  1  sticky watchdog error flag.

Behaviour:
Interface:
- Single clock `clock`.
- `reset` is synchronous and active-high.

Instruction decode:
- opcode = ir[31:27], rd = ir[26:22], rs = ir[21:17], rt = ir[16:12], aluop = ir[6:2].
- lw = opcode 01000.
- mul = opcode 00000 with aluop 00110; div = opcode 00000 with aluop 00111.
- fd reads rs: opcode in {00000, 00101, 00111, 01000, 00010, 00110}.
- fd reads rt: opcode 00000.
- fd reads rd: opcode in {00111, 00010, 00110, 00100}.

States:
- RUN, MD_WAIT.
- Reset value: RUN.
- While `reset` is high:
  - all *_we = 1 and all *_nop = 0.
  - md_mult = md_div = 0, md_timeout = 0, watchdog = 0.

RUN, evaluated in this priority order:
1. dx is mul or div:
   - Assert md_mult or md_div for exactly this cycle.
   - Freeze: pc_we = fd_we = dx_we = 0.
   - xm_nop = 1.
   - Next state MD_WAIT; watchdog loads 1.
2. branch_taken:
   - fd_nop = 1, dx_nop = 1, all we = 1.
   - Squashes the two younger instructions.
3. Load-use: dx is lw, dx.rd != 0, and dx.rd matches a register that fd reads:
   - pc_we = fd_we = 0, dx_nop = 1.
   - Exactly one bubble per hazard.
4. Otherwise: all we = 1, all nop = 0.

MD_WAIT:
- md_ready = 0:
  - Hold the freeze and xm_nop = 1.
  - Watchdog increments.
  - When watchdog reaches MD_MAX_CYCLES: set md_timeout (sticky until reset) and return to RUN.
- md_ready = 1:
  - xm_nop = 0, xm_we = 1; X/M captures the result.
  - Clear the D/X slot: dx_nop = 1 with dx_we = 1.
  - pc_we = fd_we = 1.
  - Next state RUN.
- md_mult and md_div are never asserted in MD_WAIT.
- The mul does not re-trigger, because D/X now holds a nop.

Edge cases:
- md_ready arriving in the same cycle as the start pulse is ignored; it is sampled only in MD_WAIT.
- A register-0 destination never causes a stall.
- reset asserted mid-MD_WAIT returns to RUN the next edge, with no pulse issued.
- mw_we is tied to 1.
- Outputs are combinational from state and inputs; the only state is the FSM state, the watchdog, and md_timeout.

Optional Feature:
STALL_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles [CNT_W-1:0] and flush_events [CNT_W-1:0], both reset to 0.
  - stall_cycles increments on every cycle with pc_we = 0.
  - flush_events increments on every cycle with branch_taken accepted (RUN priority 2).
  - Both counters wrap modulo 2^CNT_W.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Load-use: dx = lw r5, fd = add r6,r5,r1 -> one cycle with pc_we = 0, fd_we = 0, dx_nop = 1, then normal flow. Repeat with dx.rd = r0 -> no stall.
- mul: dx = mul r3,r1,r2, md_ready after 17 cycles -> md_mult high exactly 1 cycle; pc_we = 0 for 17 cycles; xm_we = 1 and dx_nop = 1 on the ready cycle; RUN the next cycle.
- Branch: branch_taken = 1 while fd holds a lw hazard -> fd_nop = dx_nop = 1, pc_we = 1; no stall is issued.
- Watchdog: div issued, md_ready never asserted -> md_timeout = 1 after 40 cycles, RUN resumes, flag stays high until reset.
- reset = 1 during MD_WAIT (cycle 5) -> next edge state RUN, all we = 1, md_timeout = 0, no md pulse.
- With STALL_PERF_CNT_EN: two load-use stalls plus one 17-cycle mul -> stall_cycles = 19, flush_events = 0.
